// File: rtl/turn_signal_conditioner.sv
// ---------------------------------------------------------------------------
// turn_signal_conditioner
//
// Conditions three bouncy, asynchronous turn-signal switches into clean
// registered requests for the tail-light sequencer, and generates the tick
// pulse that paces the sequencer's light steps.
//
// Each raw switch goes through a 2-flop synchronizer. A per-channel counter
// then requires DEBOUNCE_CYCLES consecutive disagreeing samples before the
// debounced state flips. The debounced states are combined into registered
// outputs. Simultaneous left and right requests are treated as a hazard.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable cycles to accept a change (1..65535)
//   TICK_DIV        : clock cycles per tick period (2..2^24)
//
// Ports
//   clk        in  : single clock, rising edge
//   reset      in  : synchronous, active-high
//   left_raw   in  : raw left-turn switch (asynchronous, bouncy)
//   right_raw  in  : raw right-turn switch (asynchronous, bouncy)
//   hazard_raw in  : raw hazard switch (asynchronous, bouncy)
//   left       out : conditioned left request (also high for hazard)
//   right      out : conditioned right request (also high for hazard)
//   hazard     out : hazard active (hazard switch, or left and right together)
//   tick       out : one-cycle pulse every TICK_DIV cycles
//
// There is no handshake: every output is a registered level or pulse that is
// valid on every cycle after reset and needs no acknowledgement.
//
// Latency from a clean raw edge to the output change is DEBOUNCE_CYCLES+3
// rising edges (2 sync + DEBOUNCE_CYCLES debounce + 1 output register).
// ---------------------------------------------------------------------------
module turn_signal_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TICK_DIV        = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic left_raw,
   input  logic right_raw,
   input  logic hazard_raw,
   output logic left,
   output logic right,
   output logic hazard,
   output logic tick
);

   // A debounce length of 1 still needs a 1-bit counter to keep the
   // declarations legal; that counter then never leaves 0.
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TW = $clog2(TICK_DIV);

   localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TCNT_MAX = TW'(TICK_DIV - 1);

   // Channel index: 0 = left, 1 = right, 2 = hazard.
   logic [2:0]    raw;
   logic [2:0]    s1;
   logic [2:0]    s2;
   logic [2:0]    deb;
   logic [CW-1:0] cnt [3];
   logic [TW-1:0] tcnt;

   assign raw = {hazard_raw, right_raw, left_raw};

   // Synchronizers and debouncers. A sample equal to the debounced state
   // clears the count, so a bounce always restarts the acceptance window.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1  <= '0;
         s2  <= '0;
         deb <= '0;
         for (int i = 0; i < 3; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s1 <= raw;
         s2 <= s1;
         for (int i = 0; i < 3; i++) begin
            if (s2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               deb[i] <= s2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   // Registered output combine: hazard drives both turn lamps, and a
   // simultaneous left+right request is promoted to hazard.
   always_ff @(posedge clk) begin
      if (reset) begin
         left   <= 1'b0;
         right  <= 1'b0;
         hazard <= 1'b0;
      end else begin
         left   <= deb[0] | deb[2];
         right  <= deb[1] | deb[2];
         hazard <= deb[2] | (deb[0] & deb[1]);
      end
   end

   // Free-running tick divider; its phase depends only on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt <= '0;
         tick <= 1'b0;
      end else begin
         tick <= (tcnt == TCNT_MAX);
         if (tcnt == TCNT_MAX) begin
            tcnt <= '0;
         end else begin
            tcnt <= tcnt + TW'(1);
         end
      end
   end

endmodule

// File: tb/tb_turn_signal_conditioner.sv
// ---------------------------------------------------------------------------
// tb_turn_signal_conditioner
//
// Two instances share the raw inputs: dut0 with the defaults
// (DEBOUNCE_CYCLES=4, TICK_DIV=4) and dut1 with DEBOUNCE_CYCLES=1,
// TICK_DIV=3. A behavioural model predicts every output of both on every
// cycle. The model describes the block by its external rules: a 2-sample
// delay line, a "last D samples all disagree" acceptance window, and an
// edge count since reset for the tick. Directed sequences add literal
// expectations for latency, bounce, conflict, glitch and tick phase.
// ---------------------------------------------------------------------------
module tb_turn_signal_conditioner;

   logic clk;
   logic reset;
   logic left_raw;
   logic right_raw;
   logic hazard_raw;
   logic left0, right0, hazard0, tick0;
   logic left1, right1, hazard1, tick1;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   turn_signal_conditioner #(.DEBOUNCE_CYCLES(4), .TICK_DIV(4)) dut0 (
      .clk(clk), .reset(reset),
      .left_raw(left_raw), .right_raw(right_raw), .hazard_raw(hazard_raw),
      .left(left0), .right(right0), .hazard(hazard0), .tick(tick0)
   );

   turn_signal_conditioner #(.DEBOUNCE_CYCLES(1), .TICK_DIV(3)) dut1 (
      .clk(clk), .reset(reset),
      .left_raw(left_raw), .right_raw(right_raw), .hazard_raw(hazard_raw),
      .left(left1), .right(right1), .hazard(hazard1), .tick(tick1)
   );

   // ---------------- checker ----------------
   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int dcv(input int m);
      return (m == 0) ? 4 : 1;
   endfunction

   function automatic int tdv(input int m);
      return (m == 0) ? 4 : 3;
   endfunction

   bit         md_p1  [6];   // index m*3+c ; c: 0 left, 1 right, 2 hazard
   bit         md_p2  [6];
   bit         md_deb [6];
   bit         md_h   [6][$];
   int         md_k   [2];
   logic [3:0] md_exp [2];   // {tick, hazard, right, left}
   bit         md_on = 1'b0;

   always @(posedge clk) begin
      logic [2:0] rawv;
      bit         all_diff;
      int         ix;
      rawv = {hazard_raw, right_raw, left_raw};
      for (int m = 0; m < 2; m++) begin
         if (reset) begin
            for (int c = 0; c < 3; c++) begin
               ix = m * 3 + c;
               md_p1[ix]  = 1'b0;
               md_p2[ix]  = 1'b0;
               md_deb[ix] = 1'b0;
               md_h[ix].delete();
            end
            md_k[m]   = 0;
            md_exp[m] = 4'b0000;
         end else begin
            md_k[m]++;
            md_exp[m][0] = md_deb[m*3+0] | md_deb[m*3+2];
            md_exp[m][1] = md_deb[m*3+1] | md_deb[m*3+2];
            md_exp[m][2] = md_deb[m*3+2] | (md_deb[m*3+0] & md_deb[m*3+1]);
            md_exp[m][3] = ((md_k[m] % tdv(m)) == 0);
            for (int c = 0; c < 3; c++) begin
               ix = m * 3 + c;
               md_h[ix].push_back(md_p2[ix]);
               if (md_h[ix].size() > dcv(m)) void'(md_h[ix].pop_front());
               if (md_h[ix].size() == dcv(m)) begin
                  all_diff = 1'b1;
                  foreach (md_h[ix][j]) if (md_h[ix][j] == md_deb[ix]) all_diff = 1'b0;
                  if (all_diff) md_deb[ix] = ~md_deb[ix];
               end
               md_p2[ix] = md_p1[ix];
               md_p1[ix] = rawv[c];
            end
         end
      end
      if (reset) md_on = 1'b1;
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      if (md_on) begin
         chk("model_dut0", {tick0, hazard0, right0, left0}, md_exp[0]);
         chk("model_dut1", {tick1, hazard1, right1, left1}, md_exp[1]);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_raw(input logic l, input logic r, input logic h);
      left_raw   = l;
      right_raw  = r;
      hazard_raw = h;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1;
      set_raw(1'b1, 1'b1, 1'b1);

      // Reset with all switches held high: outputs stay 0 during reset.
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         chk("reset_dut0", {tick0, hazard0, right0, left0}, 4'b0000);
         chk("reset_dut1", {tick1, hazard1, right1, left1}, 4'b0000);
      end
      reset = 1'b0;
      // Full latency from deassertion; tick phase from deassertion.
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         chk("rst_release_dut0", {tick0, hazard0, right0, left0},
             {((n % 4) == 0), (n >= 7) ? 3'b111 : 3'b000});
         chk("rst_release_dut1", {tick1, hazard1, right1, left1},
             {((n % 3) == 0), (n >= 4) ? 3'b111 : 3'b000});
      end
      set_raw(1'b0, 1'b0, 1'b0);
      idle(10);

      // Clean rising then falling edge on left.
      set_raw(1'b1, 1'b0, 1'b0);
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         chk("clean_rise", {1'b0, hazard0, right0, left0}, {3'b000, (n >= 7)});
      end
      set_raw(1'b0, 1'b0, 1'b0);
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         chk("clean_fall", {1'b0, hazard0, right0, left0}, {3'b000, (n < 7)});
      end
      idle(4);

      // Bounce: toggle every 2 cycles for 20 cycles, then hold high.
      for (int i = 0; i < 20; i++) begin
         set_raw(((i / 2) % 2) == 0, 1'b0, 1'b0);
         @(negedge clk);
         chk("bounce_hold_off", {3'b000, left0}, 4'b0000);
      end
      set_raw(1'b1, 1'b0, 1'b0);
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         chk("bounce_final", {3'b000, left0}, {3'b000, (n >= 7)});
      end
      set_raw(1'b0, 1'b0, 1'b0);
      idle(10);

      // Conflict: left and right together become hazard.
      set_raw(1'b1, 1'b1, 1'b0);
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         chk("conflict_on", {1'b0, hazard0, right0, left0},
             (n >= 7) ? 4'b0111 : 4'b0000);
      end
      set_raw(1'b1, 1'b0, 1'b0);
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         chk("conflict_drop", {1'b0, hazard0, right0, left0},
             (n >= 7) ? 4'b0001 : 4'b0111);
      end
      set_raw(1'b0, 1'b0, 1'b0);
      idle(10);

      // One-cycle hazard glitch: accepted by dut1 only.
      set_raw(1'b0, 1'b0, 1'b1);
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (n == 1) set_raw(1'b0, 1'b0, 1'b0);
         chk("glitch_dut1", {1'b0, hazard1, right1, left1}, (n == 4) ? 4'b0111 : 4'b0000);
         chk("glitch_dut0", {1'b0, hazard0, right0, left0}, 4'b0000);
      end
      idle(3);

      // Reset mid-period restarts the tick phase.
      for (int k = 1; k <= 2; k++) begin
         idle(k);
         reset = 1'b1;
         @(negedge clk);
         chk("tick_in_reset", {3'b000, tick0}, 4'b0000);
         reset = 1'b0;
         for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            chk("tick_phase_dut0", {3'b000, tick0}, {3'b000, ((n % 4) == 0)});
            chk("tick_phase_dut1", {3'b000, tick1}, {3'b000, ((n % 3) == 0)});
         end
      end

      // Randomized switch activity with occasional resets.
      for (int it = 0; it < 400; it++) begin
         set_raw($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0);
         reset = ($urandom_range(0, 99) < 2);
         @(negedge clk);
         reset = 1'b0;
         idle($urandom_range(0, 7));
      end
      set_raw(1'b0, 1'b0, 1'b0);
      idle(12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/turn_signal_conditioner.md
TURN_SIGNAL_CONDITIONER -- requirements
Module: turn_signal_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, the consecutive stable cycles needed to accept an input change (legal range 1..65535).
REQ-002 The block SHALL have parameter TICK_DIV, default 4, the clock cycles per tick period (legal range 2..2^24).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port left_raw, input, 1 bit: asynchronous, bouncy left-turn switch.
REQ-006 The block SHALL have port right_raw, input, 1 bit: asynchronous, bouncy right-turn switch.
REQ-007 The block SHALL have port hazard_raw, input, 1 bit: asynchronous, bouncy hazard switch.
REQ-008 The block SHALL have port left, output, 1 bit: conditioned left request, feeding the tail-light sequencer.
REQ-009 The block SHALL have port right, output, 1 bit: conditioned right request, feeding the sequencer.
REQ-010 The block SHALL have port hazard, output, 1 bit: high when the hazard condition is active.
REQ-011 The block SHALL have port tick, output, 1 bit: one-cycle pulse that paces the sequencer's light steps.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer (s1, then s2) before any other logic.
REQ-013 Each channel SHALL hold a debounced state deb and a counter cnt, with width ceil(log2(DEBOUNCE_CYCLES)), minimum 1 bit.
REQ-014 When s2 equals deb on a cycle, cnt SHALL clear to 0.
REQ-015 When s2 differs from deb and cnt is below DEBOUNCE_CYCLES-1, cnt SHALL increment by 1.
REQ-016 When s2 differs from deb and cnt equals DEBOUNCE_CYCLES-1, deb SHALL take s2 and cnt SHALL clear to 0.
REQ-017 Any bounce, meaning s2 returning to deb before acceptance, SHALL restart the count from 0; partial counts are never retained.
REQ-018 Output combine SHALL be registered:
  - left <= deb_l | deb_h
  - right <= deb_r | deb_h
  - hazard <= deb_h | (deb_l & deb_r)
REQ-019 When deb_l and deb_r are both 1 without deb_h, hazard SHALL be 1 and left = right = 1, treating simultaneous turn requests as hazard.
REQ-020 Latency from a clean raw edge to the output change SHALL be exactly DEBOUNCE_CYCLES+3 rising edges: 2 for synchronization, DEBOUNCE_CYCLES for debounce, 1 for the output register.
REQ-021 Tick divider: tcnt SHALL count 0..TICK_DIV-1 and wrap to 0.
REQ-022 tick SHALL be registered and high for exactly the one cycle following the edge at which tcnt==TICK_DIV-1, giving a period of TICK_DIV cycles.
REQ-023 tcnt SHALL run freely and independently of the switch inputs; the tick phase SHALL NOT be realigned by input changes.
REQ-024 The three channels SHALL be fully independent; simultaneous changes on several raw inputs SHALL each obey REQ-020 with no interaction.
REQ-025 The outputs SHALL contain no combinational path from any raw input.

Reset
REQ-026 While reset=1 at a rising edge, the following SHALL all clear to 0:
  - s1, s2, deb and cnt of every channel
  - tcnt
  - left, right, hazard, tick
REQ-027 Reset SHALL override every other update, including a pending debounce acceptance or a tick, in the same cycle.
REQ-028 After reset is deasserted, the first tick SHALL be high during the cycle following the TICK_DIV-th rising edge after deassertion.
REQ-029 Reset asserted mid-debounce SHALL discard the count; an input held high through reset SHALL require the full DEBOUNCE_CYCLES+3 edges after deassertion.

Verification
REQ-030 Reset: reset=1 for 2 cycles with all raw inputs =1 -> all outputs 0 during reset; left, right and hazard reach 1 at edge 7 after deassertion (defaults).
REQ-031 Clean edge: left_raw 0->1 held -> left=1 after exactly 7 edges, right=0, hazard=0; left_raw 1->0 held -> left=0 after 7 edges.
REQ-032 Bounce: left_raw toggles every 2 cycles for 20 cycles, then holds 1 -> left stays 0 throughout the toggling and rises 7 edges after the final transition.
REQ-033 Conflict: left_raw and right_raw both go to 1 together -> after 7 edges left=1, right=1, hazard=1; dropping right_raw -> after 7 edges right=0, hazard=0, left=1.
REQ-034 Tick: TICK_DIV=4 -> tick pulses once every 4 cycles, 1 cycle wide; a reset asserted mid-period restarts the phase per REQ-028.
REQ-035 Corner case: DEBOUNCE_CYCLES=1 -> latency of 4 edges; a 1-cycle glitch on hazard_raw that survives synchronization is accepted.
